// File: rtl/muller_c_pkg.sv
// Shared definitions for the muller_c formal harness.
//   - io_in / io_out bit positions on the user-project pad bus
//   - phase encoding for the 0->1->0 cover tracker
package muller_c_pkg;

  // io_in layout: [2:0] C-element inputs, then the control pins
  localparam int IDX_X_LSB = 0;
  localparam int IDX_CLR   = 3;
  localparam int IDX_SET   = 4;
  localparam int IDX_EN    = 5;

  // io_out layout
  localparam int OUT_Q        = 0;
  localparam int OUT_QN       = 1;
  localparam int OUT_ALL_HIGH = 2;
  localparam int OUT_ALL_LOW  = 3;
  localparam int OUT_COVER    = 4;
  localparam int OUT_VIOL     = 5;

  // IDLE: no input-driven rise since the last clr/set or reset
  // UP  : q rose through the C-element path
  // DONE: q then fell through the C-element path (full cycle seen)
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_UP   = 2'd1,
    PH_DONE = 2'd2
  } phase_e;

endpackage

// File: rtl/muller_c_cell.sv
// N-input Muller C-element, clock-sampled, with clr/set/en.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset (q -> 0)
//   x[N_IN-1:0]        : C-element inputs
//   clr, set, en       : clear (highest priority), set, evaluate enable
//   q                  : registered state
//   q_next             : next-state value (feeds the harness counters/flags)
//   all_high, all_low  : input agreement, combinational from x
module muller_c_cell #(
  parameter int N_IN = 3
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [N_IN-1:0] x,
  input  logic            clr,
  input  logic            set,
  input  logic            en,
  output logic            q,
  output logic            q_next,
  output logic            all_high,
  output logic            all_low
);

  assign all_high = &x;
  assign all_low  = ~(|x);

  // clr > set > en gate > C-element rule; disagreement holds state
  always_comb begin
    q_next = q;
    if (clr)           q_next = 1'b0;
    else if (set)      q_next = 1'b1;
    else if (!en)      q_next = q;
    else if (all_high) q_next = 1'b1;
    else if (all_low)  q_next = 1'b0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) q <= 1'b0;
    else          q <= q_next;
  end

endmodule

// File: rtl/muller_c_formal_harness.sv
// Muller C-element wrapped with the protocol checker and cover logic used
// for bounded-cover runs on the muller_c pad inputs.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   io_in[5:0]         : [2:0] x, [3] clr, [4] set, [5] en
//   io_out[5:0]        : [0] q, [1] ~q, [2] all_high, [3] all_low,
//                        [4] cover_sticky, [5] viol_sticky
//   io_oeb[5:0]        : tied low, every pad is an output
//   rise_cnt, fall_cnt : saturating q 0->1 / 1->0 transition counters
// Build option: define MULLER_C_ASSERT_EN to compile in the concurrent
// assertions and cover statements. Synthesised logic is the same either way.
module muller_c_formal_harness
  import muller_c_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int CNT_W = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [5:0]       io_in,
  output logic [5:0]       io_out,
  output logic [5:0]       io_oeb,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt
);

  logic            clr, set, en;
  logic [N_IN-1:0] x;
  logic            q, q_next, all_high, all_low;
  logic            rise_inc, fall_inc;
  logic            viol_hit, cover_hit;
  logic            cover_sticky, viol_sticky;
  phase_e          phase_q, phase_nxt;

  // io_in[2:N_IN] are deliberately left out when N_IN < 3
  assign x   = io_in[IDX_X_LSB +: N_IN];
  assign clr = io_in[IDX_CLR];
  assign set = io_in[IDX_SET];
  assign en  = io_in[IDX_EN];

  muller_c_cell #(.N_IN(N_IN)) u_cell (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .x        (x),
    .clr      (clr),
    .set      (set),
    .en       (en),
    .q        (q),
    .q_next   (q_next),
    .all_high (all_high),
    .all_low  (all_low)
  );

  assign rise_inc = q_next & ~q;
  assign fall_inc = ~q_next & q;

  // Only clr/set or agreeing inputs may move q; anything else is a bug
  assign viol_hit = (q_next != q) && !clr && !set && !all_high && !all_low;

  // ---- phase tracker: state register ----
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) phase_q <= PH_IDLE;
    else          phase_q <= phase_nxt;
  end

  // ---- phase tracker: next state ----
  // A fall only completes the cycle if the rise also came from the inputs;
  // a set-driven 1 falling back stays in IDLE.
  always_comb begin
    phase_nxt = phase_q;
    if (clr || set)                       phase_nxt = PH_IDLE;
    else if (en && rise_inc)              phase_nxt = PH_UP;
    else if (en && fall_inc && phase_q == PH_UP) phase_nxt = PH_DONE;
  end

  // ---- phase tracker: output ----
  // Flag on the edge that enters DONE so cover lands with the falling q.
  always_comb begin
    cover_hit = (phase_nxt == PH_DONE);
  end

  // ---- sticky flags and saturating counters ----
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cover_sticky <= 1'b0;
      viol_sticky  <= 1'b0;
      rise_cnt     <= '0;
      fall_cnt     <= '0;
    end else begin
      if (cover_hit) cover_sticky <= 1'b1;
      if (viol_hit)  viol_sticky  <= 1'b1;
      if (rise_inc && rise_cnt != '1) rise_cnt <= rise_cnt + 1'b1;
      if (fall_inc && fall_cnt != '1) fall_cnt <= fall_cnt + 1'b1;
    end
  end

  always_comb begin
    io_out               = '0;
    io_out[OUT_Q]        = q;
    io_out[OUT_QN]       = ~q;
    io_out[OUT_ALL_HIGH] = all_high;
    io_out[OUT_ALL_LOW]  = all_low;
    io_out[OUT_COVER]    = cover_sticky;
    io_out[OUT_VIOL]     = viol_sticky;
  end

  assign io_oeb = 6'b000000;

`ifdef MULLER_C_ASSERT_EN
  a_no_change_on_disagree: assert property (
    @(posedge wb_clk_i) disable iff (wb_rst_i)
      (!clr && !set && !all_high && !all_low) |=> $stable(q));

  a_viol_never: assert property (
    @(posedge wb_clk_i) disable iff (wb_rst_i) !viol_sticky);

  a_rise_monotonic: assert property (
    @(posedge wb_clk_i) disable iff (wb_rst_i)
      1'b1 |=> rise_cnt >= $past(rise_cnt));

  a_fall_monotonic: assert property (
    @(posedge wb_clk_i) disable iff (wb_rst_i)
      1'b1 |=> fall_cnt >= $past(fall_cnt));

  c_cover_cycle: cover property (
    @(posedge wb_clk_i) disable iff (wb_rst_i) cover_sticky);

  c_rise_sat: cover property (
    @(posedge wb_clk_i) disable iff (wb_rst_i) rise_cnt == '1);

  c_fall_sat: cover property (
    @(posedge wb_clk_i) disable iff (wb_rst_i) fall_cnt == '1);
`else
  // checker-free build: flags and counters only
`endif

endmodule

// File: tb/tb_muller_c_formal_harness.sv
// Directed bench for muller_c_formal_harness with hand-computed expectations.
module tb_muller_c_formal_harness;

  logic       wb_clk_i;
  logic       wb_rst_i;
  logic [5:0] io_in;
  logic [5:0] io_out;
  logic [5:0] io_oeb;
  logic [7:0] rise_cnt;
  logic [7:0] fall_cnt;

  int checks;
  int failures;

  muller_c_formal_harness #(.N_IN(3), .CNT_W(8)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .rise_cnt (rise_cnt),
    .fall_cnt (fall_cnt)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance n edges, then sample 1 time unit later
  task automatic step(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wb_rst_i = 1'b1;
    io_in    = 6'b000000;
    step(2);

    // reset state: q=0, ~q=1, x=000 -> all_low
    check("rst_io_out", io_out, 6'b001010);
    check("rst_rise",   rise_cnt, 0);
    check("rst_fall",   fall_cnt, 0);
    check("rst_oeb",    io_oeb, 6'b000000);
    wb_rst_i = 1'b0;

    // set with en=0 forces q=1
    io_in = 6'b010101;
    step(1);
    check("set_io_out", io_out, 6'b000001);
    check("set_rise",   rise_cnt, 1);

    // disagreeing inputs from q=0 hold for 10 cycles
    wb_rst_i = 1'b1;
    step(1);
    wb_rst_i = 1'b0;
    io_in = 6'b100011;
    step(10);
    check("disagree_io_out", io_out, 6'b000010);
    check("disagree_rise",   rise_cnt, 0);
    check("disagree_fall",   fall_cnt, 0);

    // en=0 blocks agreeing inputs
    io_in = 6'b000111;
    step(2);
    check("en0_hold_io_out", io_out, 6'b000110);

    // full C-element cycle: 111 rise, 101 hold x3, 000 fall
    io_in = 6'b100111;
    step(1);
    check("cyc_rise_q",  io_out[0], 1);
    check("cyc_rise_cnt", rise_cnt, 1);
    io_in = 6'b100101;
    step(3);
    check("cyc_hold_io_out", io_out, 6'b000001);
    io_in = 6'b100000;
    step(1);
    check("cyc_fall_q",   io_out[0], 0);
    check("cyc_fall_cnt", fall_cnt, 1);
    step(1);
    check("cyc_cover_io_out", io_out, 6'b011010);
    check("cyc_rise_final",   rise_cnt, 1);

    // clr+set together from q=1: clr wins, cover stays
    io_in = 6'b100111;
    step(1);
    io_in = 6'b011000;
    step(1);
    check("clrset_io_out", io_out, 6'b011010);
    check("clrset_fall",   fall_cnt, 2);

    // clr+set must drop the phase to IDLE: a later input-driven fall
    // after a set-driven rise must not count as a full cycle
    wb_rst_i = 1'b1;
    step(1);
    wb_rst_i = 1'b0;
    io_in = 6'b100111;
    step(1);
    io_in = 6'b011000;
    step(1);
    io_in = 6'b010000;
    step(1);
    check("phase_set_q", io_out[0], 1);
    io_in = 6'b100000;
    step(2);
    check("phase_idle_io_out", io_out, 6'b001010);
    check("phase_idle_rise",   rise_cnt, 2);
    check("phase_idle_fall",   fall_cnt, 2);

    // saturation: 600 alternating cycles -> 300 rises/falls, capped at 255
    wb_rst_i = 1'b1;
    step(1);
    wb_rst_i = 1'b0;
    for (int i = 0; i < 600; i++) begin
      io_in = (i % 2 == 0) ? 6'b100111 : 6'b100000;
      step(1);
      if (i == 19) begin
        check("tog20_rise", rise_cnt, 10);
        check("tog20_fall", fall_cnt, 10);
      end
      if (i == 509) begin
        check("tog510_rise", rise_cnt, 255);
        check("tog510_fall", fall_cnt, 255);
      end
    end
    check("sat_rise",   rise_cnt, 255);
    check("sat_fall",   fall_cnt, 255);
    check("sat_io_out", io_out, 6'b011010);

    // reset mid-toggle clears everything on that edge
    for (int i = 0; i < 5; i++) begin
      io_in = (i % 2 == 0) ? 6'b100111 : 6'b100000;
      step(1);
    end
    io_in    = 6'b100111;
    wb_rst_i = 1'b1;
    step(1);
    check("midrst_io_out", io_out, 6'b000110);
    check("midrst_rise",   rise_cnt, 0);
    check("midrst_fall",   fall_cnt, 0);
    wb_rst_i = 1'b0;
    step(1);
    check("resume_io_out", io_out, 6'b000101);
    check("resume_rise",   rise_cnt, 1);
    check("resume_fall",   fall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
